// File: rtl/dzcpu_useq_pkg.sv
// Shared definitions for the dzcpu microcode sequencer: flow-field codes,
// sequencer states, configuration targets and stored-word field helpers.
package dzcpu_useq_pkg;

  // Flow field of a stored micro-op word.
  typedef enum logic [2:0] {
    FLOW_NEXT   = 3'd0,
    FLOW_EOF    = 3'd1,
    FLOW_EOF_Z  = 3'd2,
    FLOW_EOF_NZ = 3'd3,
    FLOW_JCB    = 3'd4,
    FLOW_WAIT   = 3'd5,
    FLOW_BAD6   = 3'd6,
    FLOW_BAD7   = 3'd7
  } flow_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOOKUP,
    ST_CBFETCH,
    ST_CBLOOKUP,
    ST_LOAD,
    ST_RUN
  } state_e;

  // Configuration write targets.
  localparam logic [1:0] CFG_SEL_UOP  = 2'd0;
  localparam logic [1:0] CFG_SEL_LUT  = 2'd1;
  localparam logic [1:0] CFG_SEL_CB   = 2'd2;
  localparam logic [1:0] CFG_SEL_NONE = 2'd3;

  localparam int FLOW_BITS = 3;

  // Lowest bit of the flow field for a given word width.
  function automatic int flow_lsb(input int uop_w);
    return uop_w - FLOW_BITS;
  endfunction

  // Position of the PC-increment bit; also the payload width.
  function automatic int inc_bit(input int uop_w);
    return uop_w - FLOW_BITS - 1;
  endfunction

endpackage

// File: rtl/dzcpu_useq_ram.sv
// Single-write-port RAM with a registered read port. A read of the address
// being written in the same cycle returns the previous contents.
module dzcpu_useq_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port.
  // NOTE: the array has no reset so it maps onto block RAM; non-blocking
  // assignments give read-old-data when the read and write addresses collide.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: opcode/CB dispatch through writable LUTs,
// uPC state machine, conditional termination, memory-wait stalls and
// vectored interrupt flow entry. One micro-op per cycle in RUN.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UOP_WIDTH       = 17,
  parameter int UPC_WIDTH       = 8,
  parameter int NUM_IRQ         = 5,
  parameter int IRQ_FLOW_BASE   = 240,
  parameter int IRQ_FLOW_STRIDE = 3,
  localparam int CFG_AW         = (UPC_WIDTH > 8) ? UPC_WIDTH : 8,
  localparam int PAY_W          = UOP_WIDTH - 4
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iCfgWe,
  input  logic [1:0]           iCfgSel,
  input  logic [CFG_AW-1:0]    iCfgAddr,
  input  logic [UOP_WIDTH-1:0] iCfgData,
  input  logic [7:0]           iOp,
  input  logic                 iOpValid,
  output logic                 oOpReady,
  input  logic                 iFlagZ,
  input  logic                 iMemReady,
  input  logic                 iIme,
  input  logic [NUM_IRQ-1:0]   iIrq,
  output logic [NUM_IRQ-1:0]   oIrqAck,
  output logic [PAY_W-1:0]     oUop,
  output logic                 oUopValid,
  output logic                 oPcInc,
  output logic [UPC_WIDTH-1:0] oUpc,
  output logic                 oIllegal
);

  localparam int FLOW_LSB = flow_lsb(UOP_WIDTH);
  localparam int INC_BIT  = inc_bit(UOP_WIDTH);
  localparam logic [UPC_WIDTH-1:0] UPC_MAX = '1;

  state_e               state_q, state_d;
  logic [UPC_WIDTH-1:0] upc_q, upc_d;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;
  logic                 illegal_q, illegal_d;

  logic [UPC_WIDTH-1:0] store_raddr;
  logic [UOP_WIDTH-1:0] store_word;
  logic [UPC_WIDTH-1:0] lut_data, cb_data;
  logic                 uop_valid;
  logic                 advance, terminate;
  flow_e                flow;
  logic [NUM_IRQ-1:0]   irq_onehot;
  logic [31:0]          irq_vec;

  // Micro-op store, addressed by the next uPC so RUN sustains one uop/cycle.
  dzcpu_useq_ram #(.WIDTH(UOP_WIDTH), .DEPTH(1 << UPC_WIDTH)) u_store (
    .clk_i   (iClock),
    .we_i    (iCfgWe && (iCfgSel == CFG_SEL_UOP)),
    .waddr_i (iCfgAddr[UPC_WIDTH-1:0]),
    .wdata_i (iCfgData),
    .raddr_i (store_raddr),
    .rdata_o (store_word)
  );

  // Both LUTs read iOp every cycle; the word captured on the accepting edge
  // is the one consumed in the following LOOKUP/CBLOOKUP cycle.
  dzcpu_useq_ram #(.WIDTH(UPC_WIDTH), .DEPTH(256)) u_main_lut (
    .clk_i   (iClock),
    .we_i    (iCfgWe && (iCfgSel == CFG_SEL_LUT)),
    .waddr_i (iCfgAddr[7:0]),
    .wdata_i (iCfgData[UPC_WIDTH-1:0]),
    .raddr_i (iOp),
    .rdata_o (lut_data)
  );

  dzcpu_useq_ram #(.WIDTH(UPC_WIDTH), .DEPTH(256)) u_cb_lut (
    .clk_i   (iClock),
    .we_i    (iCfgWe && (iCfgSel == CFG_SEL_CB)),
    .waddr_i (iCfgAddr[7:0]),
    .wdata_i (iCfgData[UPC_WIDTH-1:0]),
    .raddr_i (iOp),
    .rdata_o (cb_data)
  );

  // Lowest pending interrupt and the uPC of its flow.
  always_comb begin
    irq_onehot = iIrq & (~iIrq + NUM_IRQ'(1));
    irq_vec    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_onehot[i]) irq_vec = 32'(IRQ_FLOW_BASE + i * IRQ_FLOW_STRIDE);
    end
  end

  assign flow = flow_e'(store_word[FLOW_LSB +: FLOW_BITS]);

  // Next-state, next-uPC and per-cycle outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    ack_d       = '0;
    illegal_d   = illegal_q;
    store_raddr = upc_q;
    uop_valid   = 1'b0;
    advance     = 1'b0;
    terminate   = 1'b0;
    unique case (state_q)
      ST_FETCH:    if (iOpValid) state_d = ST_LOOKUP;
      ST_CBFETCH:  if (iOpValid) state_d = ST_CBLOOKUP;
      ST_LOOKUP: begin
        upc_d   = lut_data;
        state_d = ST_LOAD;
      end
      ST_CBLOOKUP: begin
        upc_d   = cb_data;
        state_d = ST_LOAD;
      end
      ST_LOAD:     state_d = ST_RUN;
      ST_RUN: begin
        uop_valid = 1'b1;
        case (flow)
          FLOW_NEXT:   advance = 1'b1;
          FLOW_EOF:    terminate = 1'b1;
          FLOW_EOF_Z:  if (iFlagZ) terminate = 1'b1; else advance = 1'b1;
          FLOW_EOF_NZ: if (!iFlagZ) terminate = 1'b1; else advance = 1'b1;
          FLOW_JCB:    state_d = ST_CBFETCH;
          FLOW_WAIT: begin
            uop_valid = iMemReady;
            advance   = iMemReady;
          end
          default: begin
            terminate = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
        if (advance) begin
          if (upc_q == UPC_MAX) begin
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            upc_d       = upc_q + 1'b1;
            store_raddr = upc_q + 1'b1;
          end
        end
        if (terminate) begin
          if (iIme && (iIrq != '0)) begin
            ack_d   = irq_onehot;
            upc_d   = irq_vec[UPC_WIDTH-1:0];
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default:     state_d = ST_FETCH;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= ST_FETCH;
      upc_q     <= '0;
      ack_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      ack_q     <= ack_d;
      illegal_q <= illegal_d;
    end
  end

  assign oOpReady  = (state_q == ST_FETCH) || (state_q == ST_CBFETCH);
  assign oUopValid = uop_valid;
  assign oUop      = (state_q == ST_RUN) ? store_word[PAY_W-1:0] : '0;
  assign oPcInc    = store_word[INC_BIT] & uop_valid;
  assign oUpc      = upc_q;
  assign oIrqAck   = ack_q;
  assign oIllegal  = illegal_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed flows from the test plan plus
// a randomized phase, all checked against a procedural flow-execution model.
module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iCfgWe = 1'b0;
  logic [1:0]  iCfgSel = '0;
  logic [7:0]  iCfgAddr = '0;
  logic [16:0] iCfgData = '0;
  logic [7:0]  iOp = '0;
  logic        iOpValid = 1'b0;
  logic        oOpReady;
  logic        iFlagZ = 1'b0;
  logic        iMemReady = 1'b1;
  logic        iIme = 1'b0;
  logic [4:0]  iIrq = '0;
  logic [4:0]  oIrqAck;
  logic [12:0] oUop;
  logic        oUopValid;
  logic        oPcInc;
  logic [7:0]  oUpc;
  logic        oIllegal;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iCfgWe(iCfgWe), .iCfgSel(iCfgSel),
    .iCfgAddr(iCfgAddr), .iCfgData(iCfgData), .iOp(iOp), .iOpValid(iOpValid),
    .oOpReady(oOpReady), .iFlagZ(iFlagZ), .iMemReady(iMemReady), .iIme(iIme),
    .iIrq(iIrq), .oIrqAck(oIrqAck), .oUop(oUop), .oUopValid(oUopValid),
    .oPcInc(oPcInc), .oUpc(oUpc), .oIllegal(oIllegal)
  );

  always #5 iClock = ~iClock;

  int errors = 0;
  int checks = 0;

  // Reference contents of the three stores and the sticky error flag.
  logic [16:0] st_m  [256];
  logic [7:0]  lut_m [256];
  logic [7:0]  cb_m  [256];
  bit          illegal_m;

  bit         rnd;
  bit         z_fix;
  bit         ready_q[$];
  logic [7:0] cb_op;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [16:0] w(input logic [2:0] flow, input bit inc);
    return {flow, inc, 13'($urandom)};
  endfunction

  task automatic cfg(input logic [1:0] sel, input logic [7:0] a, input logic [16:0] d);
    iCfgWe = 1'b1; iCfgSel = sel; iCfgAddr = a; iCfgData = d;
    tick();
    iCfgWe = 1'b0;
    case (sel)
      2'd0: st_m[a] = d;
      2'd1: lut_m[a] = d[7:0];
      2'd2: cb_m[a] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic idle_checks(input string tag, input bit ready);
    #2;
    check({tag, "_rdy"}, oOpReady, ready);
    check({tag, "_vld"}, oUopValid, 0);
    check({tag, "_ill"}, oIllegal, illegal_m);
  endtask

  task automatic do_reset();
    iReset = 1'b0;
    #1;
    check("rst_vld", oUopValid, 0);
    check("rst_inc", oPcInc, 0);
    check("rst_ack", oIrqAck, 0);
    check("rst_ill", oIllegal, 0);
    check("rst_uop", oUop, 0);
    check("rst_upc", oUpc, 0);
    check("rst_rdy", oOpReady, 1);
    tick();
    iReset = 1'b1;
    illegal_m = 1'b0;
  endtask

  // Opcode acceptance, LUT lookup and store load: first uop three cycles on.
  task automatic lookup(input bit cb, input logic [7:0] op, output logic [7:0] upc);
    iOp = op; iOpValid = 1'b1;
    idle_checks(cb ? "cbfetch" : "fetch", 1);
    check("fetch_ack", oIrqAck, 0);
    tick();
    iOpValid = 1'b0; iOp = 8'($urandom);
    idle_checks("lookup", 0);
    tick();
    upc = cb ? cb_m[op] : lut_m[op];
    idle_checks("load", 0);
    check("load_upc", oUpc, upc);
    tick();
  endtask

  // Executes a flow from 'start' one uop per cycle following the flow rules.
  task automatic run(input logic [7:0] start, input int limit, output bit finished);
    logic [7:0]  upc, u, vec;
    logic [16:0] word;
    logic [2:0]  flow;
    logic [4:0]  irq;
    bit          inc, z, mr, ime, vld, term, adv;
    int          i;
    upc = start;
    finished = 1'b0;
    for (int n = 0; n < limit && !finished; n++) begin
      word = st_m[upc];
      flow = word[16:14];
      inc  = word[13];
      if (rnd) begin
        z = 1'($urandom); mr = 1'($urandom);
        ime = ($urandom_range(3) == 0); irq = 5'($urandom);
      end else begin
        z = z_fix;
        mr = (flow == 3'd5 && ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
        ime = iIme; irq = iIrq;
      end
      iFlagZ = z; iMemReady = mr; iIme = ime; iIrq = irq;
      vld = (flow == 3'd5) ? mr : 1'b1;
      #2;
      check("run_vld", oUopValid, vld);
      check("run_upc", oUpc, upc);
      check("run_uop", oUop, word[12:0]);
      check("run_inc", oPcInc, inc && vld);
      check("run_rdy", oOpReady, 0);
      check("run_ack", oIrqAck, 0);
      check("run_ill", oIllegal, illegal_m);
      term = (flow == 3'd1) || (flow == 3'd2 && z) || (flow == 3'd3 && !z) || (flow >= 3'd6);
      adv  = (flow == 3'd0) || (flow == 3'd2 && !z) || (flow == 3'd3 && z) || (flow == 3'd5 && mr);
      if (flow >= 3'd6) illegal_m = 1'b1;
      tick();
      if (adv) begin
        if (upc == 8'd255) begin
          illegal_m = 1'b1;
          finished = 1'b1;
        end else begin
          upc = upc + 8'd1;
        end
      end else if (term) begin
        if (ime && irq != 5'd0) begin
          i = 0;
          while (!irq[i]) i++;
          vec = 8'(240 + 3 * i);
          idle_checks("irqload", 0);
          check("irq_ack", oIrqAck, 5'(1 << i));
          check("irq_upc", oUpc, vec);
          if (!rnd) iIrq = '0;
          tick();
          upc = vec;
        end else begin
          finished = 1'b1;
        end
      end else if (flow == 3'd4) begin
        lookup(1'b1, cb_op, u);
        upc = u;
      end
    end
  endtask

  task automatic do_op(input logic [7:0] op);
    logic [7:0] u;
    bit f;
    lookup(1'b0, op, u);
    run(u, 200, f);
    check("flow_done", f, 1);
    if (!f) do_reset();
  endtask

  initial begin
    logic [7:0] ops [6] = '{8'h00, 8'h31, 8'h20, 8'h21, 8'h22, 8'hCB};
    logic [7:0] cbs [2] = '{8'h7C, 8'h11};
    logic [7:0] u;
    bit f;
    rnd = 1'b0; z_fix = 1'b0; cb_op = 8'h7C; illegal_m = 1'b0;

    // Reset state.
    #2;
    check("init_vld", oUopValid, 0);
    check("init_inc", oPcInc, 0);
    check("init_ack", oIrqAck, 0);
    check("init_ill", oIllegal, 0);
    check("init_uop", oUop, 0);
    check("init_upc", oUpc, 0);
    check("init_rdy", oOpReady, 1);
    repeat (2) tick();
    iReset = 1'b1;

    // Program flows.
    cfg(0, 8'd0, w(3'd1, 1));
    cfg(1, 8'h00, 17'd0);
    cfg(0, 8'd1, w(3'd0, 1)); cfg(0, 8'd2, w(3'd0, 0));
    cfg(0, 8'd3, w(3'd0, 0)); cfg(0, 8'd4, w(3'd1, 1));
    cfg(1, 8'h31, 17'd1);
    cfg(0, 8'd13, w(3'd0, 1)); cfg(0, 8'd14, w(3'd0, 0));
    cfg(0, 8'd15, w(3'd4, 0)); cfg(0, 8'd16, w(3'd1, 1));
    cfg(1, 8'hCB, 17'd13); cfg(2, 8'h7C, 17'd16); cfg(2, 8'h11, 17'd30);
    cfg(0, 8'd17, w(3'd0, 1)); cfg(0, 8'd18, w(3'd0, 0)); cfg(0, 8'd19, w(3'd2, 0));
    cfg(0, 8'd20, w(3'd0, 1)); cfg(0, 8'd21, w(3'd0, 0)); cfg(0, 8'd22, w(3'd1, 1));
    cfg(1, 8'h20, 17'd17);
    cfg(0, 8'd30, w(3'd0, 1)); cfg(0, 8'd31, w(3'd3, 0)); cfg(0, 8'd32, w(3'd1, 1));
    cfg(1, 8'h21, 17'd30);
    cfg(0, 8'd40, w(3'd0, 1)); cfg(0, 8'd41, w(3'd5, 1)); cfg(0, 8'd42, w(3'd1, 0));
    cfg(1, 8'h22, 17'd40);
    cfg(0, 8'd50, w(3'd0, 0)); cfg(0, 8'd51, w(3'd7, 1));
    cfg(1, 8'h23, 17'd50);
    cfg(0, 8'd254, w(3'd0, 0)); cfg(0, 8'd255, w(3'd0, 1));
    cfg(1, 8'h24, 17'd254);
    for (int k = 0; k < 5; k++) begin
      cfg(0, 8'(240 + 3 * k), w(3'd0, 0));
      cfg(0, 8'(241 + 3 * k), w(3'd1, 1));
    end

    // Basic flow, unmapped opcode, ignored config target.
    do_op(8'h31);
    do_op(8'h00);
    cfg(3, 8'h31, 17'd99);
    do_op(8'h31);

    // Conditional termination both ways.
    z_fix = 1'b1; do_op(8'h20); do_op(8'h21);
    z_fix = 1'b0; do_op(8'h20); do_op(8'h21);

    // CB dispatch.
    cb_op = 8'h7C; do_op(8'hCB);
    cb_op = 8'h11; do_op(8'hCB);

    // Memory wait: four stalled cycles, then release.
    ready_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    do_op(8'h22);

    // Interrupt entry at termination, then masked.
    iIme = 1'b1; iIrq = 5'b10100; do_op(8'h31);
    iIme = 1'b0; iIrq = 5'b10100; do_op(8'h31);
    iIrq = '0;

    // Randomized flows, inputs and payload rewrites.
    rnd = 1'b1;
    repeat (30) begin
      cb_op = cbs[$urandom_range(1)];
      if ($urandom_range(3) == 0) cfg(0, 8'd2, w(3'd0, 1'($urandom)));
      do_op(ops[$urandom_range(5)]);
    end
    rnd = 1'b0; iIme = 1'b0; iIrq = '0; iMemReady = 1'b1; iFlagZ = 1'b0;

    // Illegal flow code is sticky; wrap at the top of the store.
    do_op(8'h23);
    do_op(8'h31);
    do_reset();
    do_op(8'h24);
    do_op(8'h31);

    // Asynchronous reset in the middle of a flow.
    lookup(1'b0, 8'h20, u);
    run(u, 2, f);
    check("midflow_running", f, 0);
    #2;
    do_reset();
    idle_checks("post_rst", 1);
    tick();
    do_op(8'h31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Parametrised microcode sequencer for the dzcpu core. It replaces the fixed opcode-to-flow case tables and the fixed microcode ROM with writable stores, a uPC state machine, conditional termination, CB-prefix dispatch, memory-wait stalls and vectored interrupt flow entry.
- Position: between the opcode fetch path and the datapath. It emits one micro-op per cycle to the datapath decoder.

Parameters:
- UOP_WIDTH, 17: stored word width. Bits [UOP_WIDTH-1:UOP_WIDTH-3] are the flow field, bit [UOP_WIDTH-4] is the PC-increment bit, and the remaining bits are the datapath payload.
- UPC_WIDTH, 8: microcode address width. Store depth is 2^UPC_WIDTH.
- NUM_IRQ, 5: number of interrupt request lines.
- IRQ_FLOW_BASE, 8'd240: uPC of the flow for IRQ 0.
- IRQ_FLOW_STRIDE, 3: uPC spacing between consecutive IRQ flows.

Ports:
- iClock, in, 1: clock.
- iReset, in, 1: asynchronous, active-low reset.
- iCfgWe, in, 1: configuration write strobe.
- iCfgSel, in, 2: write target. 0 = uop store, 1 = main LUT, 2 = CB LUT, 3 = ignored.
- iCfgAddr, in, max(8,UPC_WIDTH): write address.
- iCfgData, in, UOP_WIDTH: write data. LUT writes use the low UPC_WIDTH bits.
- iOp, in, 8: opcode byte.
- iOpValid, in, 1: iOp valid.
- oOpReady, out, 1: sequencer accepts an opcode this cycle.
- iFlagZ, in, 1: Z flag for conditional EOF.
- iMemReady, in, 1: memory access complete.
- iIme, in, 1: interrupt master enable.
- iIrq, in, NUM_IRQ: pending interrupt requests.
- oIrqAck, out, NUM_IRQ: one-hot, one-cycle acknowledge.
- oUop, out, UOP_WIDTH-4: payload to the datapath.
- oUopValid, out, 1: oUop is to be executed this cycle.
- oPcInc, out, 1: PC increment strobe, qualified by oUopValid.
- oUpc, out, UPC_WIDTH: current uPC (debug).
- oIllegal, out, 1: sticky error flag.

Behaviour:
- Reset (iReset low, async):
  - state = FETCH, uPC = 0.
  - oUopValid, oPcInc, oIrqAck, oIllegal, oUop, oUpc all 0.
  - Store and LUT contents are not reset.
- Storage: all three stores are synchronous-read (1 cycle).
  - Config writes are honoured in any state.
  - A same-cycle read of the written address returns the old data.
- States: FETCH, LOOKUP, CBFETCH, CBLOOKUP, LOAD, RUN.
- oOpReady = 1 in FETCH and CBFETCH, otherwise 0.
- FETCH: on iOpValid, register iOp as the main LUT address and go to LOOKUP.
- LOOKUP:
  - uPC <= LUT data; go to LOAD.
  - LUT data 0 means unmapped: flow 0 (generic 1-byte op) runs. Not an error.
- CBFETCH: on iOpValid, register iOp as the CB LUT address and go to CBLOOKUP.
- CBLOOKUP: same as LOOKUP, but from the CB LUT.
- LOAD: store read of uPC is issued; go to RUN.
- Latency: opcode accepted in cycle T gives first oUopValid in T+3.
- RUN: the registered store word is decoded each cycle.
  - oUop = payload.
  - oPcInc = inc bit & oUopValid.
  - The next store address is computed combinationally, sustaining one uop per cycle.
- Flow field codes in RUN:
  - 0 NEXT: uPC+1.
  - 1 EOF: terminate.
  - 2 EOF_Z: terminate if iFlagZ, else uPC+1.
  - 3 EOF_NZ: terminate if !iFlagZ, else uPC+1.
  - 4 JCB: go to CBFETCH after this uop.
  - 5 WAIT: oUopValid = iMemReady; hold uPC and uop until iMemReady = 1, then uPC+1.
  - 6 and 7: treated as EOF, and set oIllegal.
- Terminate at cycle N:
  - If iIme and any iIrq bit is set: take the lowest set index i.
    - oIrqAck[i] = 1 in cycle N+1.
    - uPC <= IRQ_FLOW_BASE + i*IRQ_FLOW_STRIDE, truncated to UPC_WIDTH.
    - State goes to LOAD.
  - Otherwise go to FETCH; oOpReady = 1 at N+1.
- IRQ checks happen only at termination, never mid-flow.
- Wrap: NEXT/EOF_Z/EOF_NZ/WAIT advancing from uPC = 2^UPC_WIDTH-1 sets oIllegal and goes to FETCH. It does not wrap to 0.
- oIllegal clears only on reset.
- oUopValid is 0 in every state except RUN.
- Async reset mid-flow abandons the flow immediately. No partial acknowledge is held.

Decomposition:
- Shared package (z80_opcode_definitions extension):
  - flow-field codes FLOW_NEXT .. FLOW_WAIT;
  - state encodings;
  - CFG_SEL_* constants;
  - field-position localparams derived from UOP_WIDTH.
- Sub-module dzcpu_useq_ram (parameter WIDTH, DEPTH; 1 write port, registered read).
  - Instantiated three times: uop store, main LUT, CB LUT.

Test Plan:
1. Load store[1..4] = {NEXT+inc, NEXT, NEXT, EOF+inc} and LUT[0x31] = 1; drive iOp = 0x31 at T → oUopValid at T+3 through T+6, oPcInc at T+3 and T+6, oOpReady at T+7.
2. Conditional EOF: flow at 17 with EOF_Z at uPC 19. iFlagZ = 1 → 3 uops, then FETCH. iFlagZ = 0 → uops 20..22 execute, EOF at 22.
3. CB dispatch: LUT[0xCB] = 13 (JCB at 15), CB LUT[0x7C] = 16 (EOF) → after 0xCB, oOpReady rises; 0x7C gives uop 16 three cycles later.
4. WAIT: hold iMemReady = 0 for 4 cycles on a WAIT uop → oUpc constant and oUopValid = 0 for 4 cycles. Release → single valid uop, then uPC+1.
5. Interrupt: iIme = 1, iIrq = 5'b10100 at EOF → oIrqAck = 5'b00100 for exactly 1 cycle, oUpc = 246, no oOpReady. With iIme = 0 → FETCH, no ack.
6. Errors/reset: flow code 7 → oIllegal = 1 (sticky); NEXT at uPC 255 → oIllegal, FETCH. Drop iReset mid-flow → all outputs 0 asynchronously, oOpReady = 1 after release.
